// File: rtl/regtrace_pkg.sv
// Shared types and constants for the register-file trace unit.
// Entry layout depends on TRACE_PC_EN (pc stored in the entry MSBs when defined).
package regtrace_pkg;

  typedef enum logic [1:0] {
    WP_IDLE  = 2'd0,
    WP_ARMED = 2'd1,
    WP_TRIG  = 2'd2
  } wp_state_e;

  localparam logic [7:0] DROP_MAX = 8'd255;

  // Field offsets for the default configuration (DW=32, AW=5, TSW=16).
  localparam int ENTRY_DATA_LSB = 0;
  localparam int ENTRY_DATA_W   = 32;
  localparam int ENTRY_ADDR_LSB = ENTRY_DATA_LSB + ENTRY_DATA_W;
  localparam int ENTRY_ADDR_W   = 5;
  localparam int ENTRY_TS_LSB   = ENTRY_ADDR_LSB + ENTRY_ADDR_W;
  localparam int ENTRY_TS_W     = 16;
  localparam int ENTRY_PC_LSB   = ENTRY_TS_LSB + ENTRY_TS_W;

  function automatic int entry_width(input int dw, input int tsw, input int aw);
`ifdef TRACE_PC_EN
    return dw + tsw + aw + dw;
`else
    return tsw + aw + dw;
`endif
  endfunction

endpackage

// File: rtl/regfile_trace_unit_if.sv
// Snoop, control and trace-drain signals of the register-file trace unit.
// master = core/debug side, slave = the trace unit.
interface regfile_trace_unit_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int EW = 53,
  parameter int CW = 5
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] pc;
  logic          cap_en;
  logic          arm;
  logic          disarm;
  logic [AW-1:0] wp_addr;
  logic [DW-1:0] wp_data;
  logic          clr;
  logic          rd_ready;
  logic          rd_valid;
  logic [EW-1:0] rd_data;
  logic [CW-1:0] count;
  logic          ovf;
  logic [7:0]    drop_cnt;
  logic          halt_req;

  modport master (
    output wr_en, wr_addr, wr_data, pc, cap_en, arm, disarm, wp_addr, wp_data, clr, rd_ready,
    input  rd_valid, rd_data, count, ovf, drop_cnt, halt_req
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, pc, cap_en, arm, disarm, wp_addr, wp_data, clr, rd_ready,
    output rd_valid, rd_data, count, ovf, drop_cnt, halt_req
  );
endinterface

// File: rtl/regfile_trace_unit_trace_fifo.sv
// First-word-fall-through FIFO holding trace entries; head is readable while not empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int EW    = 53,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          push,
  input  logic [EW-1:0] push_data,
  input  logic          pop,
  output logic [EW-1:0] head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr_reg;
  logic [PW-1:0] rptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr_reg];
  assign count   = count_reg;

  always_ff @(posedge Clk) begin
    if (do_push && !reset) begin
      mem[wptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk) begin
    if (reset) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) wptr_reg <= wptr_reg + 1'b1;
      if (do_pop)  rptr_reg <= rptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/regfile_trace_unit.sv
// Register-file write tracer: time-stamped write log, drop accounting and a data watchpoint.
// Optional macro TRACE_PC_EN stores the writing instruction's pc in each entry.
module regfile_trace_unit
  import regtrace_pkg::*;
#(
  parameter int DW    = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS),
  parameter int DEPTH = 16,
  parameter int TSW   = 16
) (
  input logic                 Clk,
  input logic                 reset,
  regfile_trace_unit_if.slave bus
);
  localparam int EW = entry_width(DW, TSW, AW);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [TSW-1:0] ts_reg;
  wp_state_e      wp_state_reg;
  logic           halt_reg;
  logic           ovf_reg;
  logic [7:0]     drop_cnt_reg;
  logic           capture;
  logic           wp_hit;
  logic           drop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [EW-1:0]  entry;
  logic [EW-1:0]  head;
  logic [CW-1:0]  fifo_count;

  assign wp_hit  = bus.wr_en && (bus.wr_addr == bus.wp_addr) && (bus.wr_data == bus.wp_data);
  assign capture = bus.cap_en && bus.wr_en && (bus.wr_addr != '0) && (wp_state_reg != WP_TRIG);
  // A full FIFO only accepts when the head leaves in the same cycle.
  assign drop    = capture && fifo_full && !bus.rd_ready;

`ifdef TRACE_PC_EN
  assign entry = {bus.pc, ts_reg, bus.wr_addr, bus.wr_data};
`else
  logic unused_pc;
  assign unused_pc = ^bus.pc;
  assign entry     = {ts_reg, bus.wr_addr, bus.wr_data};
`endif

  trace_fifo #(
    .DEPTH (DEPTH),
    .EW    (EW),
    .CW    (CW)
  ) u_fifo (
    .Clk       (Clk),
    .reset     (reset),
    .push      (capture),
    .push_data (entry),
    .pop       (bus.rd_ready),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge Clk) begin
    if (reset) ts_reg <= '0;
    else       ts_reg <= ts_reg + 1'b1;
  end

  // A drop coinciding with clr leaves exactly that one drop recorded.
  always_ff @(posedge Clk) begin
    if (reset) begin
      ovf_reg      <= 1'b0;
      drop_cnt_reg <= '0;
    end else if (drop) begin
      ovf_reg <= 1'b1;
      if (bus.clr)                         drop_cnt_reg <= 8'd1;
      else if (drop_cnt_reg != DROP_MAX)   drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end else if (bus.clr) begin
      ovf_reg      <= 1'b0;
      drop_cnt_reg <= '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      wp_state_reg <= WP_IDLE;
      halt_reg     <= 1'b0;
    end else if (bus.disarm) begin
      wp_state_reg <= WP_IDLE;
      halt_reg     <= 1'b0;
    end else begin
      case (wp_state_reg)
        WP_IDLE: begin
          if (bus.arm) wp_state_reg <= WP_ARMED;
        end
        WP_ARMED: begin
          if (wp_hit) begin
            wp_state_reg <= WP_TRIG;
            halt_reg     <= 1'b1;
          end
        end
        default: wp_state_reg <= wp_state_reg;
      endcase
    end
  end

  assign bus.rd_valid = !fifo_empty;
  assign bus.rd_data  = head;
  assign bus.count    = fifo_count;
  assign bus.ovf      = ovf_reg;
  assign bus.drop_cnt = drop_cnt_reg;
  assign bus.halt_req = halt_reg;
endmodule
